// File: rtl/read_vga_pkg.sv
// Shared constants, state encoding and coordinate helper for the VGA tile-average block.
// Geometry: 800x600 active area split into a 4x4 grid of 200x150 tiles, each sampled
// through a centred 128x128 window.
package read_vga_pkg;

  localparam int unsigned CW       = 13;
  localparam logic [12:0] H_ACTIVE = 13'd800;
  localparam logic [12:0] V_ACTIVE = 13'd600;
  localparam logic [12:0] BLK_W    = 13'd200;
  localparam logic [12:0] BLK_H    = 13'd150;
  localparam int unsigned WIN_LOG2 = 7;
  localparam logic [12:0] WIN_SIZE = 13'(1 << WIN_LOG2);
  localparam logic [12:0] WIN_HOFF = 13'd36;
  localparam logic [12:0] WIN_VOFF = 13'd11;
  localparam int unsigned PIX_W    = 8;
  // Sum of 2^(2*WIN_LOG2) 8-bit samples always fits.
  localparam int unsigned ACC_W    = PIX_W + 2 * WIN_LOG2;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSof,
    StAccum,
    StDone
  } state_e;

  // Tile index along one axis and the offset inside that tile.
  typedef struct packed {
    logic [1:0]    idx;
    logic [CW-1:0] loc;
  } axis_t;

  // Compare chain instead of a divider; callers only use the result for in-range coords.
  function automatic axis_t split_axis(input logic [CW-1:0] c, input logic [CW-1:0] blk);
    axis_t         r;
    logic [CW-1:0] b2;
    logic [CW-1:0] b3;
    b2 = blk + blk;
    b3 = b2 + blk;
    if (c < blk) begin
      r.idx = 2'd0;
      r.loc = c;
    end else if (c < b2) begin
      r.idx = 2'd1;
      r.loc = c - blk;
    end else if (c < b3) begin
      r.idx = 2'd2;
      r.loc = c - b2;
    end else begin
      r.idx = 2'd3;
      r.loc = c - b3;
    end
    return r;
  endfunction

endpackage

// File: rtl/read_vga_tile_acc.sv
// Per-tile R/G/B accumulators.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i zeroes all sums (wins over
// add_i); add_i adds red_i/green_i/blue_i; avg_o is {R,G,B} of sum >> (2*WIN_LOG2).
module read_vga_tile_acc
  import read_vga_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [PIX_W-1:0] red_i,
  input  logic [PIX_W-1:0] green_i,
  input  logic [PIX_W-1:0] blue_i,
  output logic [23:0]      avg_o
);

  logic [ACC_W-1:0] red_q, red_d;
  logic [ACC_W-1:0] green_q, green_d;
  logic [ACC_W-1:0] blue_q, blue_d;

  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (clr_i) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end else if (add_i) begin
      red_d   = red_q + ACC_W'(red_i);
      green_d = green_q + ACC_W'(green_i);
      blue_d  = blue_q + ACC_W'(blue_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  // Top PIX_W bits of the sum are the truncated mean over the window.
  assign avg_o = {red_q[ACC_W-1 -: PIX_W], green_q[ACC_W-1 -: PIX_W], blue_q[ACC_W-1 -: PIX_W]};

endmodule

// File: rtl/read_vga_block_avg.sv
// Captures one 800x600 frame after i_Start and reports the average colour of the centred
// 128x128 window of each tile in a 4x4 grid.
// Ports: i_Clk pixel clock; i_rst_n async active-low reset; i_Start capture request;
// i_Red/i_Green/i_Blue pixel; i_H_Counter/i_V_Counter active-area coordinates;
// o_block1_avg..o_block16_avg {R,G,B} tile averages, row-major from top-left;
// o_done sticky "averages belong to the last captured frame".
module read_vga_block_avg
  import read_vga_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_rst_n,
  input  logic             i_Start,
  input  logic [PIX_W-1:0] i_Red,
  input  logic [PIX_W-1:0] i_Green,
  input  logic [PIX_W-1:0] i_Blue,
  input  logic [CW-1:0]    i_H_Counter,
  input  logic [CW-1:0]    i_V_Counter,
  output logic [23:0]      o_block1_avg,
  output logic [23:0]      o_block2_avg,
  output logic [23:0]      o_block3_avg,
  output logic [23:0]      o_block4_avg,
  output logic [23:0]      o_block5_avg,
  output logic [23:0]      o_block6_avg,
  output logic [23:0]      o_block7_avg,
  output logic [23:0]      o_block8_avg,
  output logic [23:0]      o_block9_avg,
  output logic [23:0]      o_block10_avg,
  output logic [23:0]      o_block11_avg,
  output logic [23:0]      o_block12_avg,
  output logic [23:0]      o_block13_avg,
  output logic [23:0]      o_block14_avg,
  output logic [23:0]      o_block15_avg,
  output logic [23:0]      o_block16_avg,
  output logic             o_done
);

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [15:0][23:0]  avg_q, avg_d, tile_avg;
  logic               clr, accum, load;
  axis_t              ax, ay;
  logic               pix_valid, in_win, sof_pix, last_pix;
  logic [3:0]         tile_idx;
  logic [15:0]        add_en;

  assign ax        = split_axis(i_H_Counter, BLK_W);
  assign ay        = split_axis(i_V_Counter, BLK_H);
  assign pix_valid = (i_H_Counter < H_ACTIVE) && (i_V_Counter < V_ACTIVE);
  assign in_win    = (ax.loc >= WIN_HOFF) && (ax.loc < WIN_HOFF + WIN_SIZE) &&
                     (ay.loc >= WIN_VOFF) && (ay.loc < WIN_VOFF + WIN_SIZE);
  assign tile_idx  = {ay.idx, ax.idx};
  assign sof_pix   = (i_H_Counter == '0) && (i_V_Counter == '0);
  assign last_pix  = (i_H_Counter == H_ACTIVE - 13'd1) && (i_V_Counter == V_ACTIVE - 13'd1);
  assign add_en    = (accum && pix_valid && in_win) ? (16'd1 << tile_idx) : '0;

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    clr     = 1'b0;
    accum   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          state_d = StWaitSof;
          clr     = 1'b1;
          done_d  = 1'b0;
        end
      end
      StWaitSof: begin
        if (i_Start) begin
          clr = 1'b1;
        end else if (sof_pix) begin
          state_d = StAccum;
        end
      end
      StAccum: begin
        // A restart discards the partial frame, including the pixel sampled this cycle.
        if (i_Start) begin
          clr     = 1'b1;
          state_d = StWaitSof;
        end else begin
          accum = 1'b1;
          if (last_pix) state_d = StDone;
        end
      end
      StDone: begin
        load    = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    avg_d = avg_q;
    if (load) avg_d = tile_avg;
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      avg_q   <= avg_d;
    end
  end

  for (genvar t = 0; t < 16; t++) begin : g_tile
    read_vga_tile_acc u_acc (
      .clk_i   (i_Clk),
      .rst_ni  (i_rst_n),
      .clr_i   (clr),
      .add_i   (add_en[t]),
      .red_i   (i_Red),
      .green_i (i_Green),
      .blue_i  (i_Blue),
      .avg_o   (tile_avg[t])
    );
  end

  assign o_block1_avg  = avg_q[0];
  assign o_block2_avg  = avg_q[1];
  assign o_block3_avg  = avg_q[2];
  assign o_block4_avg  = avg_q[3];
  assign o_block5_avg  = avg_q[4];
  assign o_block6_avg  = avg_q[5];
  assign o_block7_avg  = avg_q[6];
  assign o_block8_avg  = avg_q[7];
  assign o_block9_avg  = avg_q[8];
  assign o_block10_avg = avg_q[9];
  assign o_block11_avg = avg_q[10];
  assign o_block12_avg = avg_q[11];
  assign o_block13_avg = avg_q[12];
  assign o_block14_avg = avg_q[13];
  assign o_block15_avg = avg_q[14];
  assign o_block16_avg = avg_q[15];
  assign o_done        = done_q;

endmodule

// File: tb/tb_read_vga_block_avg.sv
// Randomized sparse-frame bench: only sampled pixels count, so each frame feeds a random
// subset of coordinates (window interiors, window edges, off-window and off-screen pixels)
// plus a dense "hot" tile so averages reach large values.
module tb_read_vga_block_avg;

  localparam int IDLE_C = 8000;  // off-screen coordinate used between frames

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic [12:0] h = 13'h1FFF, v = 13'h1FFF;
  logic [23:0] blk [16];
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [383:0] avg;
    logic [31:0]  cyc;
  } exp_t;

  exp_t         sb[$];
  logic [383:0] prev_exp = '0;

  // Reference sums per tile.
  int unsigned sr[16], sg[16], sbl[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  read_vga_block_avg dut (
    .i_Clk         (clk),
    .i_rst_n       (rst_n),
    .i_Start       (start),
    .i_Red         (r),
    .i_Green       (g),
    .i_Blue        (b),
    .i_H_Counter   (h),
    .i_V_Counter   (v),
    .o_block1_avg  (blk[0]),
    .o_block2_avg  (blk[1]),
    .o_block3_avg  (blk[2]),
    .o_block4_avg  (blk[3]),
    .o_block5_avg  (blk[4]),
    .o_block6_avg  (blk[5]),
    .o_block7_avg  (blk[6]),
    .o_block8_avg  (blk[7]),
    .o_block9_avg  (blk[8]),
    .o_block10_avg (blk[9]),
    .o_block11_avg (blk[10]),
    .o_block12_avg (blk[11]),
    .o_block13_avg (blk[12]),
    .o_block14_avg (blk[13]),
    .o_block15_avg (blk[14]),
    .o_block16_avg (blk[15]),
    .o_done        (done)
  );

  function automatic void model_clear();
    for (int t = 0; t < 16; t++) begin
      sr[t] = 0; sg[t] = 0; sbl[t] = 0;
    end
  endfunction

  function automatic void model_pix(input int x, input int y, input int rr, input int gg,
                                    input int bb);
    int t, lx, ly;
    if (x < 800 && y < 600) begin
      t  = (y / 150) * 4 + x / 200;
      lx = x % 200;
      ly = y % 150;
      if (lx >= 36 && lx < 36 + 128 && ly >= 11 && ly < 11 + 128) begin
        sr[t] += rr; sg[t] += gg; sbl[t] += bb;
      end
    end
  endfunction

  function automatic logic [383:0] model_avg();
    logic [383:0] e;
    for (int t = 0; t < 16; t++)
      e[t*24 +: 24] = {8'(sr[t] / 16384), 8'(sg[t] / 16384), 8'(sbl[t] / 16384)};
    return e;
  endfunction

  task automatic drive(input int x, input int y, input int rr, input int gg, input int bb,
                       input logic st);
    @(posedge clk);
    #1;
    h = 13'(x); v = 13'(y);
    r = 8'(rr); g = 8'(gg); b = 8'(bb);
    start = st;
  endtask

  task automatic check_state(input string nm, input logic [383:0] ea, input logic ed);
    checks++;
    if (done !== ed) begin
      errors++;
      $display("FAIL %s done got %b want %b", nm, done, ed);
    end
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (blk[t] !== ea[t*24 +: 24]) begin
        errors++;
        $display("FAIL %s block%0d got %h want %h", nm, t + 1, blk[t], ea[t*24 +: 24]);
      end
    end
  endtask

  task automatic rand_pix(output int x, output int y, output int rr, output int gg,
                          output int bb);
    int ex[4];
    int ey[4];
    int sel, t, ox, oy;
    ex = '{35, 36, 163, 164};
    ey = '{10, 11, 138, 139};
    sel = $urandom_range(0, 9);
    t   = $urandom_range(0, 15);
    ox  = (t % 4) * 200;
    oy  = (t / 4) * 150;
    rr  = $urandom_range(0, 255);
    gg  = $urandom_range(0, 255);
    bb  = $urandom_range(0, 255);
    if (sel < 5) begin
      x = ox + 36 + $urandom_range(0, 127);
      y = oy + 11 + $urandom_range(0, 127);
    end else if (sel < 7) begin
      x = ox + ex[$urandom_range(0, 3)];
      y = oy + $urandom_range(10, 139);
      rr = 255; gg = 255; bb = 255;
    end else if (sel < 9) begin
      x = ox + $urandom_range(35, 164);
      y = oy + ey[$urandom_range(0, 3)];
      rr = 255; gg = 255; bb = 255;
    end else begin
      x = $urandom_range(0, 830);
      y = $urandom_range(0, 630);
    end
    if (x == 799 && y == 599) x = 798;
  endtask

  // abort_at >= 0 stops the frame after that many pixels without the final pixel.
  task automatic run_frame(input int npix, input int nhot, input int hot_t,
                           input bit check_hold, input int abort_at);
    int x, y, rr, gg, bb, tot, c;
    logic [383:0] e;
    drive(IDLE_C, IDLE_C, 0, 0, 0, 1'b1);
    model_clear();
    drive(IDLE_C, IDLE_C, 0, 0, 0, 1'b0);
    if (check_hold) check_state("hold_on_start", prev_exp, 1'b0);
    drive(0, 0, 9, 9, 9, 1'b0);
    tot = npix + nhot;
    for (int i = 0; i < tot; i++) begin
      if (i == abort_at) return;
      if ($urandom_range(0, tot - 1) < nhot) begin
        x  = (hot_t % 4) * 200 + 36 + $urandom_range(0, 127);
        y  = (hot_t / 4) * 150 + 11 + $urandom_range(0, 127);
        rr = $urandom_range(200, 255);
        gg = $urandom_range(0, 255);
        bb = $urandom_range(100, 255);
      end else begin
        rand_pix(x, y, rr, gg, bb);
      end
      drive(x, y, rr, gg, bb, 1'b0);
      model_pix(x, y, rr, gg, bb);
    end
    drive(799, 599, 255, 255, 255, 1'b0);
    c = cyc;
    model_pix(799, 599, 255, 255, 255);
    e = model_avg();
    sb.push_back('{avg: e, cyc: 32'(c + 2)});
    prev_exp = e;
    repeat (3) drive(IDLE_C, IDLE_C, 0, 0, 0, 1'b0);
  endtask

  task automatic wait_sb(input string nm);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s done_timeout pending %0d want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every rising o_done must match the oldest expected frame.
  initial begin
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev === 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got 1 want 0");
        end else begin
          e = sb.pop_front();
          if (32'(cyc) != e.cyc) begin
            errors++;
            $display("FAIL done_latency got cycle %0d want %0d", cyc, e.cyc);
          end
          for (int t = 0; t < 16; t++) begin
            checks++;
            if (blk[t] !== e.avg[t*24 +: 24]) begin
              errors++;
              $display("FAIL frame block%0d got %h want %h", t + 1, blk[t], e.avg[t*24 +: 24]);
            end
          end
        end
      end
      done_prev = done;
    end
  end

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check_state("in_reset", '0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state("after_reset", '0, 1'b0);

    // Frame A, then o_done and outputs must hold through a long idle stretch.
    run_frame(4000, 4400, $urandom_range(0, 15), 1'b1, -1);
    wait_sb("frame_a");
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      for (int t = 0; t < 16; t++) if (blk[t] !== prev_exp[t*24 +: 24]) bad++;
      if (done !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sticky_idle got %0d bad samples want 0", bad);
    end

    // Frame B: new start drops o_done, old averages held until DONE.
    run_frame(4000, 4400, $urandom_range(0, 15), 1'b1, -1);
    wait_sb("frame_b");

    // Restart mid-accumulation, then a full frame C.
    run_frame(4000, 0, 0, 1'b1, 1500);
    run_frame(4000, 4400, $urandom_range(0, 15), 1'b0, -1);
    wait_sb("frame_c");

    // Reset in the middle of a frame.
    run_frame(4000, 4400, 5, 1'b1, 2000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_state("mid_reset", '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    prev_exp = '0;
    @(negedge clk);
    check_state("after_mid_reset", '0, 1'b0);

    // Frame D after reset.
    run_frame(4000, 4400, $urandom_range(0, 15), 1'b1, -1);
    wait_sb("frame_d");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
